dff_pipe_ce: RTL

Parametrised register pipeline built from clock-enabled D flip-flops: WIDTH-bit data shifted through DEPTH stages with one common clock enable. It combines synchronous reset, asynchronous clear, parallel load, a selectable tap output and a saturating fill counter. Used wherever a datapath needs an enable-gated delay line that tells downstream logic when its contents are valid.

---
 rtl/dff_pipe_ce_pkg.sv | 22 ++
 rtl/dff_pipe_ce_if.sv | 31 +++
 rtl/dff_pipe_ce_stage.sv | 27 ++
 rtl/dff_pipe_ce.sv | 99 +++++++++
 4 files changed

// File: rtl/dff_pipe_ce_pkg.sv
// rtl/dff_pipe_ce_pkg.sv - shared types and width helpers for the clock-enabled register pipeline
package dff_pkg;

    // Stage-select width: at least one bit even for a single stage
    function automatic int tw_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Fill-counter width: must hold the value depth itself
    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Per-cycle stage update decoded once from srst/load/ce
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        SRST  = 2'd3
    } mode_e;

endpackage

// File: rtl/dff_pipe_ce_if.sv
// rtl/dff_pipe_ce_if.sv - data/control bundle for the register pipeline
interface dff_pipe_ce_if
    import dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int TW = tw_of(DEPTH);
    localparam int CW = cw_of(DEPTH);

    logic                   ce;
    logic                   load;
    logic [WIDTH-1:0]       d;
    logic [DEPTH*WIDTH-1:0] pd;
    logic [TW-1:0]          tap_sel;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       q_tap;
    logic [DEPTH*WIDTH-1:0] q_all;
    logic [CW-1:0]          fill_cnt;
    logic                   primed;

    modport master (
        output ce, load, d, pd, tap_sel,
        input  q, q_tap, q_all, fill_cnt, primed
    );

    modport slave (
        input  ce, load, d, pd, tap_sel,
        output q, q_tap, q_all, fill_cnt, primed
    );
endinterface

// File: rtl/dff_pipe_ce_stage.sv
// rtl/dff_pipe_ce_stage.sv - one WIDTH-bit clock-enabled stage with async clear and sync reset
module dff_ce_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             srst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q;

    // Stage register: clear wins, then sync reset, then enabled capture
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= RST_VAL;
        end else if (srst) begin
            q_q <= RST_VAL;
        end else if (ce) begin
            q_q <= d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/dff_pipe_ce.sv
// rtl/dff_pipe_ce.sv - enable-gated delay line with parallel load, tap mux and fill counter
module dff_pipe_ce
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       srst,
    dff_pipe_ce_if.slave bus
);
    localparam int CW = cw_of(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    mode_e            mode;
    logic             stage_ce;
    logic             stage_srst;
    logic [WIDTH-1:0] stg [DEPTH];
    logic [CW-1:0]    fill_cnt_q;
    logic [CW-1:0]    fill_cnt_d;

    // Decode the one update mode that applies this cycle, in priority order
    always_comb begin
        mode = HOLD;
        if (srst) begin
            mode = SRST;
        end else if (bus.load) begin
            mode = LOAD;
        end else if (bus.ce) begin
            mode = SHIFT;
        end
    end

    assign stage_srst = (mode == SRST);
    assign stage_ce   = (mode == SHIFT) || (mode == LOAD);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] stage_d;

        if (i == 0) begin : g_head
            assign prev = bus.d;
        end else begin : g_body
            assign prev = stg[i-1];
        end

        assign stage_d = (mode == LOAD) ? bus.pd[i*WIDTH +: WIDTH] : prev;

        dff_ce_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk  (clk),
            .clr  (clr),
            .srst (stage_srst),
            .ce   (stage_ce),
            .d    (stage_d),
            .q    (stg[i])
        );
    end

    // Next fill count: load fills instantly, shifts count up and saturate at DEPTH
    always_comb begin
        fill_cnt_d = fill_cnt_q;
        case (mode)
            SRST:    fill_cnt_d = '0;
            LOAD:    fill_cnt_d = FULL;
            SHIFT:   fill_cnt_d = (fill_cnt_q == FULL) ? fill_cnt_q : fill_cnt_q + CW'(1);
            default: fill_cnt_d = fill_cnt_q;
        endcase
    end

    // Fill counter register, cleared asynchronously with the stages
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fill_cnt_q <= '0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // Pack stages for q_all; out-of-range tap selects fall back to the last stage
    always_comb begin
        bus.q_all = '0;
        bus.q_tap = stg[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            bus.q_all[i*WIDTH +: WIDTH] = stg[i];
            if (int'(bus.tap_sel) == i) begin
                bus.q_tap = stg[i];
            end
        end
    end

    assign bus.q        = stg[DEPTH-1];
    assign bus.fill_cnt = fill_cnt_q;
    assign bus.primed   = (fill_cnt_q == FULL);
endmodule
